// File: rtl/mem_arb_types_pkg.sv
// Shared types for the round-robin memory arbiter: FSM states, op encoding and
// a helper that sizes channel-index fields.
package mem_arb_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    // Width of a channel index; a single channel still gets a 1-bit field.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// Combinational round-robin picker. Rotates the request vector so the search
// starts one past the last grant, takes the first set bit, then maps the
// offset back to an absolute channel index.
module mem_rr_picker
    import mem_arb_types::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last_grant,
    output logic              o_grant_valid,
    output logic [IDX_W-1:0]  o_grant
);

    int unsigned       w_start;
    int unsigned       w_off;
    logic              w_found;
    logic [NUM_CH-1:0] w_rot;

    // Rotate, priority-encode, un-rotate.
    always_comb begin
        w_start = (32'(i_last_grant) + 32'd1) % NUM_CH;
        w_rot   = '0;
        w_found = 1'b0;
        w_off   = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_rot[k] = i_req[IDX_W'((w_start + k) % NUM_CH)];
        end
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = k;
            end
        end
        o_grant_valid = w_found;
        o_grant       = IDX_W'((w_start + w_off) % NUM_CH);
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel round-robin, non-preemptive memory arbiter. One access is in
// flight at a time; the winner's request fields are latched at grant so the
// channel may change or drop them while the access is outstanding.
module mem_arbiter_rr
    import mem_arb_types::*;
#(
    parameter  int unsigned NUM_CH = 2,
    parameter  int unsigned ADDR_W = 16,
    parameter  int unsigned DATA_W = 16,
    localparam int unsigned MASK_W = DATA_W / 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        i_ch_read,
    input  logic [NUM_CH-1:0]        i_ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] i_ch_address,
    input  logic [NUM_CH*DATA_W-1:0] i_ch_wdata,
    input  logic [NUM_CH*MASK_W-1:0] i_ch_byte_enable,
    output logic [NUM_CH-1:0]        o_ch_resp,
    output logic [DATA_W-1:0]        o_ch_rdata,
    output logic                     o_mem_read,
    output logic                     o_mem_write,
    output logic [ADDR_W-1:0]        o_mem_address,
    output logic [DATA_W-1:0]        o_mem_wdata,
    output logic [MASK_W-1:0]        o_mem_byte_enable,
    input  logic                     i_mem_resp,
    input  logic [DATA_W-1:0]        i_mem_rdata
);

    localparam int unsigned IDX_W = idx_width(NUM_CH);

    arb_state_t        r_state,      w_state_d;
    logic [IDX_W-1:0]  r_last_grant, w_last_grant_d;
    logic [IDX_W-1:0]  r_grant,      w_grant_d;
    mem_op_t           r_op,         w_op_d;
    logic [ADDR_W-1:0] r_addr,       w_addr_d;
    logic [DATA_W-1:0] r_wdata,      w_wdata_d;
    logic [MASK_W-1:0] r_mask,       w_mask_d;
    logic [NUM_CH-1:0] r_resp,       w_resp_d;
    logic [DATA_W-1:0] r_rdata,      w_rdata_d;

    logic [NUM_CH-1:0] w_req;
    logic              w_pick_valid;
    logic [IDX_W-1:0]  w_pick;

    assign w_req = i_ch_read | i_ch_write;

    mem_rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .i_req         (w_req),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_pick_valid),
        .o_grant       (w_pick)
    );

    // Next-state: arbitrate in IDLE, wait for memory in BUSY, pulse resp in RESP.
    always_comb begin
        w_state_d      = r_state;
        w_last_grant_d = r_last_grant;
        w_grant_d      = r_grant;
        w_op_d         = r_op;
        w_addr_d       = r_addr;
        w_wdata_d      = r_wdata;
        w_mask_d       = r_mask;
        w_resp_d       = '0;
        w_rdata_d      = r_rdata;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_d      = w_pick;
                    w_last_grant_d = w_pick;
                    // Read wins when both read and write are raised.
                    w_op_d         = i_ch_read[w_pick] ? OP_READ : OP_WRITE;
                    w_addr_d       = i_ch_address[32'(w_pick) * ADDR_W +: ADDR_W];
                    w_wdata_d      = i_ch_wdata[32'(w_pick) * DATA_W +: DATA_W];
                    w_mask_d       = i_ch_byte_enable[32'(w_pick) * MASK_W +: MASK_W];
                    w_state_d      = BUSY;
                end
            end
            BUSY: begin
                if (i_mem_resp) begin
                    w_resp_d[r_grant] = 1'b1;
                    if (r_op == OP_READ) begin
                        w_rdata_d = i_mem_rdata;
                    end
                    w_state_d = RESP;
                end
            end
            RESP: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_last_grant <= IDX_W'(NUM_CH - 1);
            r_grant      <= '0;
            r_op         <= OP_READ;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mask       <= '0;
            r_resp       <= '0;
            r_rdata      <= '0;
        end else begin
            r_state      <= w_state_d;
            r_last_grant <= w_last_grant_d;
            r_grant      <= w_grant_d;
            r_op         <= w_op_d;
            r_addr       <= w_addr_d;
            r_wdata      <= w_wdata_d;
            r_mask       <= w_mask_d;
            r_resp       <= w_resp_d;
            r_rdata      <= w_rdata_d;
        end
    end

    assign o_mem_read        = (r_state == BUSY) && (r_op == OP_READ);
    assign o_mem_write       = (r_state == BUSY) && (r_op == OP_WRITE);
    assign o_mem_address     = r_addr;
    assign o_mem_wdata       = r_wdata;
    assign o_mem_byte_enable = r_mask;
    assign o_ch_resp         = r_resp;
    assign o_ch_rdata        = r_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with four channels. Inputs are driven and
// outputs checked 1 time unit after each rising edge.
module tb_mem_arbiter_rr;

    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned MW  = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_read;
    logic [NCH-1:0]    ch_write;
    logic [NCH*AW-1:0] ch_address;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH*MW-1:0] ch_byte_enable;
    logic [NCH-1:0]    ch_resp;
    logic [DW-1:0]     ch_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_wdata;
    logic [MW-1:0]     mem_byte_enable;
    logic              mem_resp;
    logic [DW-1:0]     mem_rdata;

    // Memory side: either hand-driven or a zero-wait responder.
    logic              mem_zw;
    logic              man_resp;
    logic [DW-1:0]     man_rdata;

    assign mem_resp  = mem_zw ? (mem_read | mem_write) : man_resp;
    assign mem_rdata = mem_zw ? (mem_address ^ 16'h5A5A) : man_rdata;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr #(
        .NUM_CH (NCH),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_ch_read        (ch_read),
        .i_ch_write       (ch_write),
        .i_ch_address     (ch_address),
        .i_ch_wdata       (ch_wdata),
        .i_ch_byte_enable (ch_byte_enable),
        .o_ch_resp        (ch_resp),
        .o_ch_rdata       (ch_rdata),
        .o_mem_read       (mem_read),
        .o_mem_write      (mem_write),
        .o_mem_address    (mem_address),
        .o_mem_wdata      (mem_wdata),
        .o_mem_byte_enable(mem_byte_enable),
        .i_mem_resp       (mem_resp),
        .i_mem_rdata      (mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        ch_read        = '0;
        ch_write       = '0;
        ch_address     = '0;
        ch_wdata       = '0;
        ch_byte_enable = '0;
        mem_zw         = 1'b0;
        man_resp       = 1'b0;
        man_rdata      = '0;
        step();
        step();
        chk("rst_resp",  32'(ch_resp),     32'h0);
        chk("rst_rd",    32'(mem_read),    32'h0);
        chk("rst_wr",    32'(mem_write),   32'h0);
        chk("rst_addr",  32'(mem_address), 32'h0);
        chk("rst_rdata", 32'(ch_rdata),    32'h0);
        rst = 1'b0;

        // 1: ch2 read, memory answers on the second BUSY cycle.
        ch_read[2]          = 1'b1;
        ch_address[2*AW+:AW] = 16'h1234;
        step();
        chk("t1_rd_c1",  32'(mem_read),    32'h1);
        chk("t1_addr",   32'(mem_address), 32'h1234);
        chk("t1_resp_b", 32'(ch_resp),     32'h0);
        step();
        chk("t1_rd_c2",  32'(mem_read),    32'h1);
        man_resp  = 1'b1;
        man_rdata = 16'hBEEF;
        step();
        chk("t1_rd_off", 32'(mem_read),    32'h0);
        chk("t1_resp",   32'(ch_resp),     32'h4);
        chk("t1_rdata",  32'(ch_rdata),    32'hBEEF);
        man_resp   = 1'b0;
        ch_read[2] = 1'b0;
        step();
        chk("t1_resp_0", 32'(ch_resp),     32'h0);
        chk("t1_hold",   32'(ch_rdata),    32'hBEEF);

        // 2: restore channel-0 priority, then all four read with zero-wait memory.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t2_rst_rdata", 32'(ch_rdata), 32'h0);
        for (int i = 0; i < 4; i++) ch_address[i*AW+:AW] = 16'h1000 + 16'(i);
        mem_zw  = 1'b1;
        ch_read = 4'hF;
        for (int j = 0; j < 6; j++) begin
            int g;
            g = j % 4;
            step();
            chk("t2_rd",    32'(mem_read),    32'h1);
            chk("t2_addr",  32'(mem_address), 32'(16'h1000 + 16'(g)));
            step();
            chk("t2_resp",  32'(ch_resp),     32'(4'b0001 << g));
            chk("t2_rdata", 32'(ch_rdata),    32'((16'h1000 + 16'(g)) ^ 16'h5A5A));
            if (j == 5) ch_read = '0;
            step();
            chk("t2_idle",  32'(ch_resp),     32'h0);
        end
        mem_zw = 1'b0;

        // 3: ch1 write; read data register must not change.
        ch_write[1]             = 1'b1;
        ch_address[1*AW+:AW]     = 16'h0040;
        ch_wdata[1*DW+:DW]       = 16'hA5A5;
        ch_byte_enable[1*MW+:MW] = 2'b01;
        step();
        chk("t3_wr",    32'(mem_write),       32'h1);
        chk("t3_rd",    32'(mem_read),        32'h0);
        chk("t3_addr",  32'(mem_address),     32'h0040);
        chk("t3_wdata", 32'(mem_wdata),       32'hA5A5);
        chk("t3_mask",  32'(mem_byte_enable), 32'h1);
        man_resp  = 1'b1;
        man_rdata = 16'hDEAD;
        step();
        chk("t3_resp",  32'(ch_resp),         32'h2);
        chk("t3_rdata", 32'(ch_rdata),        32'h4A5B);
        chk("t3_wroff", 32'(mem_write),       32'h0);
        man_resp    = 1'b0;
        ch_write[1] = 1'b0;
        step();
        chk("t3_ahold", 32'(mem_address),     32'h0040);

        // 4: reset while ch3 is in BUSY, then ch3 is granted again.
        ch_read[3]          = 1'b1;
        ch_address[3*AW+:AW] = 16'h3333;
        step();
        chk("t4_rd",    32'(mem_read),    32'h1);
        chk("t4_addr",  32'(mem_address), 32'h3333);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_rd_0",  32'(mem_read),    32'h0);
        chk("t4_resp0", 32'(ch_resp),     32'h0);
        chk("t4_addr0", 32'(mem_address), 32'h0);
        step();
        chk("t4_regnt", 32'(mem_read),    32'h1);
        chk("t4_resp1", 32'(ch_resp),     32'h0);
        man_resp  = 1'b1;
        man_rdata = 16'h0033;
        step();
        chk("t4_resp",  32'(ch_resp),     32'h8);
        chk("t4_rdata", 32'(ch_rdata),    32'h0033);
        man_resp   = 1'b0;
        ch_read[3] = 1'b0;
        step();

        // 5: ch0 read+write together; address changes during BUSY.
        ch_read[0]               = 1'b1;
        ch_write[0]              = 1'b1;
        ch_address[0*AW+:AW]      = 16'h0ABC;
        ch_wdata[0*DW+:DW]        = 16'hFFFF;
        ch_byte_enable[0*MW+:MW]  = 2'b11;
        step();
        chk("t5_rd",    32'(mem_read),    32'h1);
        chk("t5_wr",    32'(mem_write),   32'h0);
        chk("t5_addr",  32'(mem_address), 32'h0ABC);
        ch_address[0*AW+:AW] = 16'h0DEF;
        step();
        chk("t5_ahold", 32'(mem_address), 32'h0ABC);
        man_resp  = 1'b1;
        man_rdata = 16'h1357;
        step();
        chk("t5_resp",  32'(ch_resp),     32'h1);
        chk("t5_rdata", 32'(ch_rdata),    32'h1357);
        man_resp    = 1'b0;
        ch_read[0]  = 1'b0;
        ch_write[0] = 1'b0;
        step();

        // 6: stray mem_resp in IDLE, then ch0 drops its request during BUSY.
        man_resp  = 1'b1;
        man_rdata = 16'h9999;
        step();
        chk("t6_spur1", 32'(ch_resp),  32'h0);
        step();
        chk("t6_spur2", 32'(ch_resp),  32'h0);
        chk("t6_rdkeep", 32'(ch_rdata), 32'h1357);
        man_resp             = 1'b0;
        ch_read[0]           = 1'b1;
        ch_address[0*AW+:AW] = 16'h0600;
        step();
        chk("t6_rd",    32'(mem_read),    32'h1);
        chk("t6_addr",  32'(mem_address), 32'h0600);
        ch_read[0] = 1'b0;
        step();
        chk("t6_rd2",   32'(mem_read),    32'h1);
        man_resp  = 1'b1;
        man_rdata = 16'h2468;
        step();
        chk("t6_resp",  32'(ch_resp),     32'h1);
        chk("t6_rdata", 32'(ch_rdata),    32'h2468);
        man_resp = 1'b0;
        step();
        chk("t6_idle",  32'(ch_resp),     32'h0);
        chk("t6_rdoff", 32'(mem_read),    32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-channel memory arbiter. Lets several LC-3b-style requesters share one physical memory port: CPU fetch/data, a future cache, or a DMA engine.
- Each channel side and the memory side use the same read/write/resp handshake as the existing CPU memory interface.
- Grants are round-robin and non-preemptive.
- Exactly one transaction is outstanding at a time. Request fields are latched at grant.

Parameters:
NUM_CH, 2, number of requester channels (>=1)
ADDR_W, 16, address width
DATA_W, 16, data width (multiple of 8)
MASK_W, DATA_W/8, byte-enable width (derived; not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
ch_read  in  NUM_CH  per-channel read request, held until that channel's ch_resp
ch_write  in  NUM_CH  per-channel write request, held until that channel's ch_resp
ch_address  in  NUM_CH*ADDR_W  packed per-channel address, channel i at [i*ADDR_W +: ADDR_W]
ch_wdata  in  NUM_CH*DATA_W  packed per-channel write data
ch_byte_enable  in  NUM_CH*MASK_W  packed per-channel byte mask
ch_resp  out  NUM_CH  one-cycle completion pulse, one-hot
ch_rdata  out  DATA_W  registered read data, broadcast, valid while ch_resp is high
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_byte_enable  out  MASK_W  memory byte mask
mem_resp  in  1  memory completion
mem_rdata  in  DATA_W  memory read data, valid with mem_resp

Behaviour:
Reset:
- Synchronous, active-high. Reset is one clock, clk; rst is synchronous and active-high.
- All outputs go to 0. State goes to IDLE. last_grant goes to NUM_CH-1, so channel 0 wins first.
- Reset mid-transaction abandons the access. Strobes drop at the edge and no ch_resp is issued.

States:
- IDLE: strobes 0.
  - req[i] = ch_read[i] | ch_write[i].
  - If any req, pick a winner by searching from (last_grant+1) mod NUM_CH upward with wrap-around.
  - Latch the winner's address, wdata, mask and op into the mem_* registers. Set last_grant to the winner. Go to BUSY.
  - If no req, stay in IDLE.
- BUSY: mem_read or mem_write is held high per the latched op.
  - On mem_resp: drop the strobe at the next edge. Register mem_rdata into ch_rdata. Set ch_resp[grant]=1. Go to RESP.
- RESP: ch_resp[grant] is high for exactly this cycle. Strobes 0. Go to IDLE. No arbitration happens in RESP.

Timing:
- Request seen in cycle t: strobe high from t+1.
- mem_resp in cycle u: ch_resp high in cycle u+1, IDLE in u+2.
- Minimum 3 cycles per access with zero-wait memory.

Rules:
- If ch_read and ch_write are both high on one channel, the access is a read. Write data is ignored.
- ch_rdata holds its value after RESP. It updates only on a completed read. It is unchanged after a write.
- mem_address, mem_wdata and mem_byte_enable hold their latched values outside BUSY.
- A granted channel that drops its request during BUSY does not abort the access. It completes and ch_resp still pulses.
- mem_resp in IDLE or RESP is ignored.
- Requests arriving during BUSY or RESP wait. No request is lost while held.
- Fairness: with all channels requesting continuously, every channel is served once per NUM_CH transactions.
- NUM_CH=1 degenerates to a registered pass-through with the same 3-state timing.

Decomposition:
- Shared package mem_arb_types holds:
  - enum arb_state_t {IDLE, BUSY, RESP}
  - mem op encoding (OP_READ, OP_WRITE)
- Sub-module mem_rr_picker (combinational):
  - Inputs: req vector, last_grant index.
  - Outputs: grant_valid and grant index, from a rotate / priority-encode / un-rotate search.
  - Parametrised by NUM_CH.
- The arbiter top holds the FSM, latch registers and resp/rdata registers.

Test Plan (NUM_CH=4, ADDR_W=16, DATA_W=16):
1. Reset, then ch_read[2]=1 at addr 0x1234, memory responds in 2 cycles with 0xBEEF:
   - mem_read high for exactly 2 cycles, mem_address=0x1234.
   - ch_resp=4'b0100 for one cycle with ch_rdata=0xBEEF.
   - Access takes 4 cycles.
2. All 4 channels read continuously, zero-wait memory:
   - Grant order 0,1,2,3,0,1.
   - One ch_resp every 3 cycles.
3. ch_write[1]=1, addr 0x0040, wdata 0xA5A5, mask 2'b01:
   - mem_write=1 with exactly those values.
   - ch_rdata keeps its previous value.
   - ch_resp=4'b0010.
4. Assert rst during BUSY on ch3:
   - Strobes 0 the next cycle. No ch_resp.
   - A following ch3 request is granted first after channel 0 priority is restored.
5. ch_read[0] and ch_write[0] both high, plus ch_address[0] changed mid-BUSY:
   - Read issued.
   - mem_address keeps the value latched at grant.
6. mem_resp pulsed while IDLE, and ch0 drops its request during BUSY:
   - No spurious ch_resp from the IDLE pulse.
   - ch0's access still completes with ch_resp[0].
